logic4_table_checker: RTL and testbench

- Receiving/checking end of a 4-level gate truth-table sweep.
- A stimulus source streams one row per handshake: operand A (swept input), operand B (column constant) and the observed gate output, each 2-bit encoded 0/1/x/z.
- The block computes the expected IEEE-1364 4-state result for the selected gate (AND, XOR, bufif0, notif1), compares it with the observed value, checks row order, and reports pass/fail after a complete 16-row table.

---
 rtl/logic4_pkg.sv | 37 +++
 rtl/logic4_eval.sv | 58 +++++
 rtl/logic4_table_checker.sv | 202 ++++++++++++++++++++
 tb/tb_logic4_table_checker.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic4_pkg.sv
// ----------------------------------------------------------------------------
// logic4_pkg
// Shared definitions for the 4-level (0/1/x/z) gate truth-table checker:
//   - 2-bit value encoding constants (L4_0, L4_1, L4_X, L4_Z)
//   - gate selector constants (OP_AND, OP_XOR, OP_BUFIF0, OP_NOTIF1)
//   - checker FSM state type
//   - small helper to classify a value as unknown (x or z)
// ----------------------------------------------------------------------------
package logic4_pkg;

  // Value encoding. Bit 1 set means the value is not a clean 0/1.
  localparam logic [1:0] L4_0 = 2'b00;
  localparam logic [1:0] L4_1 = 2'b01;
  localparam logic [1:0] L4_X = 2'b10;
  localparam logic [1:0] L4_Z = 2'b11;

  // Gate under test.
  localparam logic [1:0] OP_AND    = 2'b00;
  localparam logic [1:0] OP_XOR    = 2'b01;
  localparam logic [1:0] OP_BUFIF0 = 2'b10;
  localparam logic [1:0] OP_NOTIF1 = 2'b11;

  // A full table is 16 rows, indexed {a,b}.
  localparam logic [3:0] LAST_ROW = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // True for x and z: both behave as "unknown" when they reach a gate input.
  function automatic logic is_unknown(input logic [1:0] v);
    return v[1];
  endfunction

endpackage

// File: rtl/logic4_eval.sv
// ----------------------------------------------------------------------------
// logic4_eval
// Purely combinational IEEE-1364 4-state evaluator for one gate.
//
// Ports:
//   op_i   in  2  gate select (OP_AND / OP_XOR / OP_BUFIF0 / OP_NOTIF1)
//   a_i    in  2  operand A, or data input for the tri-state gates
//   b_i    in  2  operand B, or control input for the tri-state gates
//   exp_o  out 2  expected gate output, same 0/1/x/z encoding
// ----------------------------------------------------------------------------
module logic4_eval
  import logic4_pkg::*;
(
  input  logic [1:0] op_i,
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic [1:0] exp_o
);

  always_comb begin
    // Every unresolved case below lands on x.
    exp_o = L4_X;
    case (op_i)
      OP_AND: begin
        // A controlling 0 on either side dominates unknowns.
        if ((a_i == L4_0) || (b_i == L4_0)) begin
          exp_o = L4_0;
        end else if ((a_i == L4_1) && (b_i == L4_1)) begin
          exp_o = L4_1;
        end
      end

      OP_XOR: begin
        if (!is_unknown(a_i) && !is_unknown(b_i)) begin
          exp_o = {1'b0, a_i[0] ^ b_i[0]};
        end
      end

      OP_BUFIF0: begin
        if (b_i == L4_1) begin
          exp_o = L4_Z;
        end else if (b_i == L4_0) begin
          // A floating data input is driven out as x, not passed through as z.
          exp_o = (a_i == L4_Z) ? L4_X : a_i;
        end
      end

      default: begin // OP_NOTIF1
        if (b_i == L4_0) begin
          exp_o = L4_Z;
        end else if (b_i == L4_1) begin
          exp_o = is_unknown(a_i) ? L4_X : {1'b0, ~a_i[0]};
        end
      end
    endcase
  end

endmodule

// File: rtl/logic4_table_checker.sv
// ----------------------------------------------------------------------------
// logic4_table_checker
// Receiving end of a 16-row 4-state truth-table sweep. Each accepted row
// carries operands a, b and the observed gate output; the block recomputes
// the expected value, counts mismatches, checks row order and, after the
// 16th row (or an idle timeout), reports a registered pass/fail verdict.
//
// Parameters:
//   TIMEOUT_CYCLES  idle RUN cycles tolerated between rows (0 = no timeout)
//   STRICT_ORDER    1 = rows must arrive as {a,b} = 0..15
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, start_op     one-cycle start pulse and gate select latched with it
//   in_valid/in_ready   row handshake (in_ready high only in RUN)
//   in_a, in_b, in_obs  row operands and observed output (0/1/x/z encoded)
//   busy, done          state is RUN / state is DONE
//   pass                verdict, meaningful while done
//   mismatch_cnt        rows whose observation differed from expectation
//   order_err, timeout  sticky error flags
//   first_fail_row/vld  index of the first mismatching row
//   exp_last            expected value of the last accepted row (debug)
// ----------------------------------------------------------------------------
module logic4_table_checker
  import logic4_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter bit          STRICT_ORDER   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] start_op,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_a,
  input  logic [1:0] in_b,
  input  logic [1:0] in_obs,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] mismatch_cnt,
  output logic       order_err,
  output logic       timeout,
  output logic [3:0] first_fail_row,
  output logic       first_fail_vld,
  output logic [1:0] exp_last
);

  // The timer only has to reach TIMEOUT_CYCLES-1: the abort fires on the
  // edge that would have taken it to TIMEOUT_CYCLES.
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST =
    TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e        state_q,     state_d;
  logic [1:0]    op_q,        op_d;
  logic [3:0]    row_idx_q,   row_idx_d;
  logic [TW-1:0] timer_q,     timer_d;
  logic [4:0]    mis_cnt_q,   mis_cnt_d;
  logic          order_err_q, order_err_d;
  logic          timeout_q,   timeout_d;
  logic [3:0]    ff_row_q,    ff_row_d;
  logic          ff_vld_q,    ff_vld_d;
  logic [1:0]    exp_last_q,  exp_last_d;
  logic          pass_q,      pass_d;

  // --------------------------------------------------------------------------
  // Row evaluation
  // --------------------------------------------------------------------------
  logic [1:0] exp_w;
  logic       accept;
  logic       row_mis;
  logic       row_ooo;
  logic       timer_hit;

  logic4_eval u_eval (
    .op_i  (op_q),
    .a_i   (in_a),
    .b_i   (in_b),
    .exp_o (exp_w)
  );

  assign in_ready = (state_q == RUN);

  // start takes priority: a row presented alongside a restart is dropped,
  // otherwise it would be scored against the table that is being abandoned.
  assign accept    = in_valid && in_ready && !start;
  assign row_mis   = (in_obs != exp_w);
  assign row_ooo   = STRICT_ORDER && ({in_a, in_b} != row_idx_q);
  assign timer_hit = (TIMEOUT_CYCLES != 0) && (timer_q == TO_LAST);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    row_idx_d   = row_idx_q;
    timer_d     = timer_q;
    mis_cnt_d   = mis_cnt_q;
    order_err_d = order_err_q;
    timeout_d   = timeout_q;
    ff_row_d    = ff_row_q;
    ff_vld_d    = ff_vld_q;
    exp_last_d  = exp_last_q;
    pass_d      = pass_q;

    if (start) begin
      // Restart from any state with a clean slate.
      state_d     = RUN;
      op_d        = start_op;
      row_idx_d   = '0;
      timer_d     = '0;
      mis_cnt_d   = '0;
      order_err_d = 1'b0;
      timeout_d   = 1'b0;
      ff_row_d    = '0;
      ff_vld_d    = 1'b0;
      exp_last_d  = '0;
      pass_d      = 1'b0;
    end else if (state_q == RUN) begin
      if (accept) begin
        exp_last_d = exp_w;
        if (row_mis) begin
          mis_cnt_d = mis_cnt_q + 5'd1;
          if (!ff_vld_q) begin
            ff_row_d = row_idx_q;
            ff_vld_d = 1'b1;
          end
        end
        if (row_ooo) begin
          order_err_d = 1'b1;
        end
        // row_idx wraps to 0 after the last row; it is re-zeroed on start anyway.
        row_idx_d = row_idx_q + 4'd1;
        timer_d   = '0;
        if (row_idx_q == LAST_ROW) begin
          state_d = DONE;
        end
      end else if (timer_hit) begin
        timeout_d = 1'b1;
        state_d   = DONE;
      end else if (TIMEOUT_CYCLES != 0) begin
        timer_d = timer_q + 1'b1;
      end

      // Verdict is captured on the edge that enters DONE, from the final values.
      if (state_d == DONE) begin
        pass_d = (mis_cnt_d == 5'd0) && !order_err_d && !timeout_d;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_AND;
      row_idx_q   <= '0;
      timer_q     <= '0;
      mis_cnt_q   <= '0;
      order_err_q <= 1'b0;
      timeout_q   <= 1'b0;
      ff_row_q    <= '0;
      ff_vld_q    <= 1'b0;
      exp_last_q  <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      row_idx_q   <= row_idx_d;
      timer_q     <= timer_d;
      mis_cnt_q   <= mis_cnt_d;
      order_err_q <= order_err_d;
      timeout_q   <= timeout_d;
      ff_row_q    <= ff_row_d;
      ff_vld_q    <= ff_vld_d;
      exp_last_q  <= exp_last_d;
      pass_q      <= pass_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign busy           = (state_q == RUN);
  assign done           = (state_q == DONE);
  assign pass           = pass_q;
  assign mismatch_cnt   = mis_cnt_q;
  assign order_err      = order_err_q;
  assign timeout        = timeout_q;
  assign first_fail_row = ff_row_q;
  assign first_fail_vld = ff_vld_q;
  assign exp_last       = exp_last_q;

endmodule

// File: tb/tb_logic4_table_checker.sv
// ----------------------------------------------------------------------------
// Self-checking bench for logic4_table_checker (TIMEOUT_CYCLES=8,
// STRICT_ORDER=1). Expected gate outputs come from character truth tables;
// run results come from a scoreboard updated per accepted row.
// ----------------------------------------------------------------------------
module tb_logic4_table_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] start_op;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_a, in_b, in_obs;
  logic       busy, done, pass;
  logic [4:0] mismatch_cnt;
  logic       order_err, timeout;
  logic [3:0] first_fail_row;
  logic       first_fail_vld;
  logic [1:0] exp_last;

  always #5 clk = ~clk;

  logic4_table_checker #(.TIMEOUT_CYCLES(8), .STRICT_ORDER(1'b1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .start_op       (start_op),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_a           (in_a),
    .in_b           (in_b),
    .in_obs         (in_obs),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .mismatch_cnt   (mismatch_cnt),
    .order_err      (order_err),
    .timeout        (timeout),
    .first_fail_row (first_fail_row),
    .first_fail_vld (first_fail_vld),
    .exp_last       (exp_last)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Truth tables, row-major by a (0,1,x,z), column b (0,1,x,z).
  string tbl[4];

  // Scoreboard for the current run.
  logic [1:0] cur_op;
  int         m_mis, m_ff_row, m_idx;
  bit         m_ff_vld, m_order, m_to;
  logic [1:0] m_exp_last;

  function automatic logic [1:0] ref_eval(input logic [1:0] op, input int idx);
    string t;
    byte   c;
    t = tbl[op];
    c = t[idx];
    if (c == "0") return 2'd0;
    if (c == "1") return 2'd1;
    if (c == "x") return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [16:0] got_vec();
    return {busy, done, pass, mismatch_cnt, order_err, timeout,
            first_fail_vld, first_fail_row, exp_last};
  endfunction

  function automatic logic [16:0] exp_vec();
    bit fin, p;
    fin = (m_idx == 16) || m_to;
    p   = fin && (m_mis == 0) && !m_order && !m_to;
    return {!fin, fin, p, 5'(m_mis), m_order, m_to, m_ff_vld, 4'(m_ff_row), m_exp_last};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] op);
    start = 1'b1; start_op = op;
    cycle();
    start = 1'b0;
    cur_op = op; m_mis = 0; m_ff_row = 0; m_idx = 0;
    m_ff_vld = 0; m_order = 0; m_to = 0; m_exp_last = 2'd0;
  endtask

  // Presents one row (after 'gap' idle cycles) and records it in the scoreboard.
  task automatic feed(input int idx, input logic [1:0] obs, input int gap);
    logic [1:0] e;
    repeat (gap) cycle();
    in_a = 2'(idx >> 2); in_b = 2'(idx & 3); in_obs = obs; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    e = ref_eval(cur_op, idx);
    m_exp_last = e;
    if (obs !== e) begin
      m_mis++;
      if (!m_ff_vld) begin m_ff_vld = 1; m_ff_row = m_idx; end
    end
    if (idx != m_idx) m_order = 1;
    m_idx++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cycle();
    n_checks++;
    if ({got_vec(), in_ready} !== 18'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", {got_vec(), in_ready});
    end
    rst_n = 1'b1;
    // A row offered in IDLE must be ignored.
    in_a = 2'd1; in_b = 2'd1; in_obs = 2'd3; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    n_checks++;
    if ({got_vec(), in_ready} !== 18'd0) begin
      n_fail++; $display("FAIL idle_ignores_row: got %h want 0", {got_vec(), in_ready});
    end
    $display("test_reset done");
  endtask

  task automatic test_and_pass();
    logic [16:0] held;
    do_start(2'd0);
    for (int i = 0; i < 16; i++) begin
      feed(i, ref_eval(cur_op, i), $urandom_range(0, 3));
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL and_row%0d: got %h want %h", i, got_vec(), exp_vec());
      end
    end
    // DONE must not accept rows and must hold results.
    held = exp_vec();
    in_a = 2'd0; in_b = 2'd0; in_obs = 2'd3; in_valid = 1'b1;
    repeat (3) cycle();
    in_valid = 1'b0;
    n_checks++;
    if ({got_vec(), in_ready} !== {held, 1'b0}) begin
      n_fail++; $display("FAIL and_done_hold: got %h want %h", {got_vec(), in_ready}, {held, 1'b0});
    end
    $display("test_and_pass done: mis=%0d pass=%0b", mismatch_cnt, pass);
  endtask

  task automatic test_xor_mismatch();
    do_start(2'd1);
    for (int i = 0; i < 16; i++) begin
      feed(i, (i == 6) ? 2'b01 : ref_eval(cur_op, i), $urandom_range(0, 2));
      if (i == 6) begin
        n_checks++;
        if ({exp_last, mismatch_cnt} !== {2'b10, 5'd1}) begin
          n_fail++; $display("FAIL xor_row6: got exp_last=%b mis=%0d want exp_last=10 mis=1", exp_last, mismatch_cnt);
        end
      end
    end
    n_checks++;
    if (got_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL xor_end: got %h want %h", got_vec(), exp_vec());
    end
    $display("test_xor_mismatch done: ff_row=%0d pass=%0b", first_fail_row, pass);
  endtask

  task automatic test_bufif0();
    do_start(2'd2);
    for (int i = 0; i < 16; i++) begin
      feed(i, (i == 12) ? 2'b11 : ref_eval(cur_op, i), 0);
      if (i == 1 || i == 12) begin
        n_checks++;
        if (exp_last !== ((i == 1) ? 2'b11 : 2'b10)) begin
          n_fail++; $display("FAIL bufif0_exp_row%0d: got %b want %b", i, exp_last, (i == 1) ? 2'b11 : 2'b10);
        end
      end
    end
    n_checks++;
    if (got_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL bufif0_end: got %h want %h", got_vec(), exp_vec());
    end
    $display("test_bufif0 done: mis=%0d ff_row=%0d", mismatch_cnt, first_fail_row);
  endtask

  task automatic test_notif1_order();
    int idx;
    do_start(2'd3);
    for (int i = 0; i < 16; i++) begin
      idx = (i == 3) ? 4 : (i == 4) ? 3 : i;
      feed(idx, (i == 9) ? ~ref_eval(cur_op, idx) : ref_eval(cur_op, idx), 1);
    end
    n_checks++;
    if (got_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL notif1_order_end: got %h want %h", got_vec(), exp_vec());
    end
    $display("test_notif1_order done: order_err=%0b mis=%0d", order_err, mismatch_cnt);
  endtask

  task automatic test_timeout();
    do_start(2'($urandom_range(0, 3)));
    for (int i = 0; i < 5; i++) feed(i, ref_eval(cur_op, i), 0);
    for (int k = 1; k <= 8; k++) begin
      cycle();
      n_checks++;
      if ({done, timeout, busy} !== {k == 8, k == 8, k != 8}) begin
        n_fail++; $display("FAIL timeout_cycle%0d: got %b want %b", k, {done, timeout, busy}, {k == 8, k == 8, k != 8});
      end
    end
    m_to = 1;
    n_checks++;
    if (got_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL timeout_end: got %h want %h", got_vec(), exp_vec());
    end
    $display("test_timeout done: timeout=%0b pass=%0b", timeout, pass);
  endtask

  task automatic test_start_midrun();
    do_start(2'd0);
    for (int i = 0; i < 3; i++) feed(i, 2'd3, 0);
    // Restart with a row in the same cycle: the row must be dropped.
    start = 1'b1; start_op = 2'd1;
    in_a = 2'd0; in_b = 2'd0; in_obs = 2'd3; in_valid = 1'b1;
    cycle();
    start = 1'b0; in_valid = 1'b0;
    cur_op = 2'd1; m_mis = 0; m_ff_row = 0; m_idx = 0;
    m_ff_vld = 0; m_order = 0; m_to = 0; m_exp_last = 2'd0;
    n_checks++;
    if (got_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL restart_clear: got %h want %h", got_vec(), exp_vec());
    end
    for (int i = 0; i < 16; i++) feed(i, ref_eval(cur_op, i), $urandom_range(0, 3));
    n_checks++;
    if (got_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL restart_run_end: got %h want %h", got_vec(), exp_vec());
    end
    $display("test_start_midrun done: pass=%0b", pass);
  endtask

  task automatic test_reset_midtable();
    do_start(2'd2);
    for (int i = 0; i < 7; i++) feed(i, 2'd0, 0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({got_vec(), in_ready} !== 18'd0) begin
      n_fail++; $display("FAIL reset_async: got %h want 0", {got_vec(), in_ready});
    end
    cycle(); cycle();
    n_checks++;
    if ({got_vec(), in_ready} !== 18'd0) begin
      n_fail++; $display("FAIL reset_hold: got %h want 0", {got_vec(), in_ready});
    end
    rst_n = 1'b1;
    cycle();
    do_start(2'd3);
    for (int i = 0; i < 16; i++) feed(i, ref_eval(cur_op, i), $urandom_range(0, 2));
    n_checks++;
    if (got_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_fresh_run: got %h want %h", got_vec(), exp_vec());
    end
    $display("test_reset_midtable done: pass=%0b", pass);
  endtask

  task automatic test_random();
    int order[16];
    int p, tmp;
    logic [1:0] obs;
    for (int r = 0; r < 8; r++) begin
      do_start(2'($urandom_range(0, 3)));
      for (int i = 0; i < 16; i++) order[i] = i;
      if ($urandom_range(0, 2) == 0) begin
        p = $urandom_range(0, 14);
        tmp = order[p]; order[p] = order[p + 1]; order[p + 1] = tmp;
      end
      for (int i = 0; i < 16; i++) begin
        obs = ref_eval(cur_op, order[i]);
        if ($urandom_range(0, 3) == 0) obs = obs ^ 2'($urandom_range(1, 3));
        feed(order[i], obs, $urandom_range(0, 3));
        n_checks++;
        if (got_vec() !== exp_vec()) begin
          n_fail++; $display("FAIL rand_run%0d_row%0d: got %h want %h", r, i, got_vec(), exp_vec());
        end
      end
      $display("test_random run %0d: op=%0d mis=%0d order_err=%0b pass=%0b", r, cur_op, mismatch_cnt, order_err, pass);
    end
  endtask

  initial begin
    tbl[0] = "000001xx0xxx0xxx"; // AND
    tbl[1] = "01xx10xxxxxxxxxx"; // XOR
    tbl[2] = "0zxx1zxxxzxxxzxx"; // bufif0(data=a, ctrl=b)
    tbl[3] = "z1xxz0xxzxxxzxxx"; // notif1(data=a, ctrl=b)
    start = 1'b0; start_op = 2'd0; in_valid = 1'b0;
    in_a = 2'd0; in_b = 2'd0; in_obs = 2'd0;

    test_reset();
    test_and_pass();
    test_xor_mismatch();
    test_bufif0();
    test_notif1_order();
    test_timeout();
    test_start_midrun();
    test_reset_midtable();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
